// File: rtl/dram_controller_if.sv
// CPU-side strobes and DRAM-side address/strobe lines of the fast-page-mode controller.
// The CPU/system side is the master; the controller is the slave.
interface dram_controller_if #(
  parameter int ROW_BITS = 11
);
  logic                DRAM;
  logic                AS;
  logic                UDS;
  logic                LDS;
  logic                RW;
  logic [22:1]         ADDR;
  logic [ROW_BITS-1:0] MADDR;
  logic                RAS;
  logic                CASU;
  logic                CASL;
  logic                WE;
  logic                DTACK_DRAM;

  modport master (
    output DRAM, AS, UDS, LDS, RW, ADDR,
    input  MADDR, RAS, CASU, CASL, WE, DTACK_DRAM
  );

  modport slave (
    input  DRAM, AS, UDS, LDS, RW, ADDR,
    output MADDR, RAS, CASU, CASL, WE, DTACK_DRAM
  );
endinterface

// File: rtl/dram_controller.sv
// Fast-page-mode DRAM controller: row/column multiplexing, per-byte CAS, late-strobe writes
// and periodic CAS-before-RAS refresh. Every DRAM-facing output comes straight from a flop.
module dram_controller #(
  parameter int ROW_BITS    = 11,
  parameter int REFRESH_INT = 300,
  parameter int T_RP        = 2,
  parameter int T_RCD       = 1,
  parameter int T_CAS       = 2
) (
  input  logic             CLK,
  input  logic             RST,
  dram_controller_if.slave bus
);

  localparam int REF_W = $clog2(REFRESH_INT);

  typedef enum logic [2:0] {
    IDLE, ROW, COL, ACK, PRE, REF_CAS, REF_RAS, REF_END
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [REF_W-1:0]    ref_cnt_q, ref_cnt_d;
  logic                ref_pend_q, ref_pend_d;
  logic [ROW_BITS-1:0] maddr_q, maddr_d;
  logic                ras_q, ras_d;
  logic                casu_q, casu_d;
  logic                casl_q, casl_d;
  logic                we_q, we_d;
  logic                dtack_q, dtack_d;
  logic                dram_q, as_q, uds_q, lds_q, rw_q;
  logic                ref_wrap, ref_take;
  logic [ROW_BITS-1:0] row_addr, col_addr;

  assign row_addr = bus.ADDR[2*ROW_BITS:ROW_BITS+1];
  assign col_addr = bus.ADDR[ROW_BITS:1];

  assign bus.MADDR      = maddr_q;
  assign bus.RAS        = ras_q;
  assign bus.CASU       = casu_q;
  assign bus.CASL       = casl_q;
  assign bus.WE         = we_q;
  assign bus.DTACK_DRAM = dtack_q;

  // CPU strobes are resampled once so the FSM never sees a changing input mid-cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dram_q <= 1'b1;
      as_q   <= 1'b1;
      uds_q  <= 1'b1;
      lds_q  <= 1'b1;
      rw_q   <= 1'b1;
    end else begin
      dram_q <= bus.DRAM;
      as_q   <= bus.AS;
      uds_q  <= bus.UDS;
      lds_q  <= bus.LDS;
      rw_q   <= bus.RW;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      maddr_q    <= '0;
      ras_q      <= 1'b1;
      casu_q     <= 1'b1;
      casl_q     <= 1'b1;
      we_q       <= 1'b1;
      dtack_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      maddr_q    <= maddr_d;
      ras_q      <= ras_d;
      casu_q     <= casu_d;
      casl_q     <= casl_d;
      we_q       <= we_d;
      dtack_q    <= dtack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    maddr_d   = maddr_q;
    ras_d     = ras_q;
    casu_d    = casu_q;
    casl_d    = casl_q;
    we_d      = we_q;
    dtack_d   = dtack_q;
    ref_take  = 1'b0;
    ref_wrap  = (ref_cnt_q == REF_W'(REFRESH_INT - 1));
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);

    unique case (state_q)
      IDLE: begin
        maddr_d = row_addr;
        if (ref_pend_q) begin
          state_d  = REF_CAS;
          casu_d   = 1'b0;
          casl_d   = 1'b0;
          we_d     = 1'b1;
          ref_take = 1'b1;
        end else if (!as_q && !dram_q) begin
          state_d = ROW;
          ras_d   = 1'b0;
          we_d    = rw_q;
          cnt_d   = '0;
        end
      end
      ROW: begin
        if (as_q) begin
          state_d = PRE;
          ras_d   = 1'b1;
          we_d    = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == 8'(T_RCD - 1)) begin
          state_d = COL;
          maddr_d = col_addr;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      COL: begin
        // CAS waits for a data strobe, which may arrive late on writes.
        if (as_q) begin
          state_d = PRE;
          ras_d   = 1'b1;
          casu_d  = 1'b1;
          casl_d  = 1'b1;
          we_d    = 1'b1;
          cnt_d   = '0;
        end else if (casu_q && casl_q) begin
          if (!uds_q || !lds_q) begin
            casu_d = uds_q;
            casl_d = lds_q;
            cnt_d  = '0;
          end
        end else if (cnt_q == 8'(T_CAS - 1)) begin
          state_d = ACK;
          dtack_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK: begin
        if (as_q) begin
          state_d = PRE;
          dtack_d = 1'b1;
          ras_d   = 1'b1;
          casu_d  = 1'b1;
          casl_d  = 1'b1;
          we_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      PRE: begin
        if (cnt_q == 8'(T_RP - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REF_CAS: begin
        state_d = REF_RAS;
        ras_d   = 1'b0;
        cnt_d   = '0;
      end
      REF_RAS: begin
        if (cnt_q == 8'd2) begin
          state_d = REF_END;
          ras_d   = 1'b1;
          casu_d  = 1'b1;
          casl_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REF_END: begin
        state_d = PRE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    // A wrap while a request is still pending simply merges into it.
    ref_pend_d = ref_pend_q;
    if (ref_wrap) begin
      ref_pend_d = 1'b1;
    end else if (ref_take) begin
      ref_pend_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_dram_controller.sv
// Randomized scoreboard bench for dram_controller: stimulus queues expected DRAM cycles,
// a negedge monitor matches RAS/CAS/DTACK activity against them and checks refresh shape.
module tb_dram_controller;

  localparam int ROW_BITS = 11;
  localparam int REF_INT  = 300;
  localparam int T_RP     = 2;
  localparam int T_RCD    = 1;
  localparam int T_CAS    = 2;

  typedef struct {
    int row;
    int col;
    int we;
    int u;
    int l;
    int known;
    int row_e;
    int strobe_s;
    int ack;
  } exp_t;

  logic CLK;
  logic RST;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q[$];
  bit   idle_only;
  int   ref_cnt;

  dram_controller_if #(.ROW_BITS(ROW_BITS)) bus ();

  dram_controller #(
    .ROW_BITS(ROW_BITS), .REFRESH_INT(REF_INT), .T_RP(T_RP), .T_RCD(T_RCD), .T_CAS(T_CAS)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edge index since reset release: the value after the N-th rising edge is N.
  always @(posedge CLK or negedge RST) begin
    if (!RST) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Edge on which RAS should fall for an access whose AS was first sampled on edge s,
  // assuming the controller was idle: a refresh requested on a wrap edge W runs first
  // and the controller is back in IDLE after edge W+8.
  function automatic int row_edge_f(input int s);
    if (s >= REF_INT && (s % REF_INT) <= 8) return s - (s % REF_INT) + 9;
    return s + 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- monitor ----------------
  bit   act, in_ref, dtack_seen;
  exp_t cur;
  int   cas_e, ref_cas_e, ref_ras_e;
  logic p_ras, p_casu, p_casl, p_dt;

  always @(negedge CLK) begin
    if (!RST) begin
      act = 0; in_ref = 0; dtack_seen = 0;
      ref_cnt = 0;
    end else begin
      if (p_casu && p_casl && !(bus.CASU && bus.CASL) && bus.RAS) begin
        in_ref = 1;
        ref_cas_e = cyc;
        ref_cnt++;
        chk("ref_we_high", bus.WE, 1);
        chk("ref_dtack_high", bus.DTACK_DRAM, 1);
        if (idle_only) chk("ref_period", cyc % REF_INT, 1);
      end
      if (p_ras && !bus.RAS) begin
        if (in_ref) begin
          ref_ras_e = cyc;
          chk("ref_cas_before_ras", cyc - ref_cas_e, 1);
        end else if (q.size() == 0) begin
          chk("spurious_ras", 1, 0);
        end else begin
          cur = q.pop_front();
          act = 1;
          dtack_seen = 0;
          cas_e = max2(cur.row_e + T_RCD + 1, cur.strobe_s + 1);
          chk("row_addr", int'(bus.MADDR), cur.row);
          chk("we_level", bus.WE, cur.we);
          if (cur.known) chk("ras_edge", cyc, cur.row_e);
        end
      end
      if (p_casu && p_casl && !(bus.CASU && bus.CASL) && !bus.RAS && act) begin
        chk("col_addr", int'(bus.MADDR), cur.col);
        chk("casu", bus.CASU, cur.u);
        chk("casl", bus.CASL, cur.l);
        if (cur.known) chk("cas_edge", cyc, cas_e);
      end
      if (p_dt && !bus.DTACK_DRAM) begin
        if (!act) chk("dtack_without_access", 1, 0);
        else begin
          dtack_seen = 1;
          if (cur.known) chk("dtack_edge", cyc, cas_e + T_CAS);
        end
      end
      if (!p_ras && bus.RAS) begin
        if (in_ref) begin
          chk("ref_ras_width", cyc - ref_ras_e, 3);
          chk("ref_cas_release", int'(bus.CASU & bus.CASL), 1);
          in_ref = 0;
        end else if (act) begin
          chk("ack_seen", int'(dtack_seen), cur.ack);
          act = 0;
        end
      end
    end
    p_ras = bus.RAS; p_casu = bus.CASU; p_casl = bus.CASL; p_dt = bus.DTACK_DRAM;
  end

  // ---------------- stimulus ----------------
  task automatic release_bus();
    bus.AS = 1'b1; bus.UDS = 1'b1; bus.LDS = 1'b1; bus.DRAM = 1'b1; bus.RW = 1'b1;
  endtask

  task automatic wait_dtack();
    int k;
    for (k = 0; k < 80; k++) begin
      if (!bus.DTACK_DRAM) break;
      @(posedge CLK); #1;
    end
    if (k == 80) chk("dtack_timeout", 0, 1);
  endtask

  task automatic wait_mod(input int m);
    do begin @(posedge CLK); #1; end while ((cyc % REF_INT) != m);
  endtask

  task automatic access(input logic [23:0] baddr, input bit rw, input bit u, input bit l,
                        input int late, input bit dsel, input bit abort, input bit aligned,
                        input int hold);
    exp_t e;
    int   s;
    @(posedge CLK); #1;
    s = cyc + 1;
    bus.ADDR = baddr[22:1];
    bus.RW   = rw;
    bus.DRAM = !dsel;
    bus.AS   = 1'b0;
    if (late == 0) begin bus.UDS = u; bus.LDS = l; end
    if (dsel) begin
      e.row      = int'((baddr >> 12) & 24'h7FF);
      e.col      = int'((baddr >> 1) & 24'h7FF);
      e.we       = rw;
      e.u        = u;
      e.l        = l;
      e.known    = int'(s < REF_INT || (s % REF_INT) >= 40 || aligned);
      e.row_e    = row_edge_f(s);
      e.strobe_s = s + late;
      e.ack      = !abort;
      q.push_back(e);
    end
    repeat (late) begin @(posedge CLK); #1; end
    if (late > 0) begin bus.UDS = u; bus.LDS = l; end
    if (abort) begin
      @(posedge CLK); #1;
    end else if (dsel) begin
      wait_dtack();
      repeat (hold + 1) begin @(posedge CLK); #1; end
    end else begin
      repeat (8) begin @(posedge CLK); #1; end
    end
    release_bus();
    repeat (3 + $urandom_range(0, 6)) @(posedge CLK);
  endtask

  initial begin
    exp_t e;
    int   sel;
    bit   u, l, rw;
    checks = 0; errors = 0; idle_only = 0;
    bus.ADDR = '0;
    release_bus();
    RST = 1'b1;
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ras", bus.RAS, 1);
    chk("rst_casu", bus.CASU, 1);
    chk("rst_casl", bus.CASL, 1);
    chk("rst_we", bus.WE, 1);
    chk("rst_dtack", bus.DTACK_DRAM, 1);
    chk("rst_maddr", int'(bus.MADDR), 0);
    @(negedge CLK); #2 RST = 1'b1;

    // Quiet period: refresh every REF_INT edges, nothing else.
    idle_only = 1;
    while (cyc < 605) begin @(posedge CLK); #1; end
    chk("idle_ref_count", ref_cnt, 2);
    idle_only = 0;

    wait_mod(50);
    access(24'h123456, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1);
    access(24'h100001, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0);
    access(24'h234568, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    access(24'h3ABCDE, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
    wait_mod(REF_INT - 1);
    access(24'h4F0F0E, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      u   = (sel == 2);
      l   = (sel == 1);
      rw  = $urandom_range(0, 1);
      access(24'h100000 + 24'($urandom_range(0, 24'h7FFFFF)), rw, u, l,
             rw ? 0 : $urandom_range(0, 3), $urandom_range(0, 7) != 0, 1'b0, 1'b0,
             $urandom_range(0, 2));
    end

    // Reset asserted mid-cycle while the controller is acknowledging.
    wait_mod(50);
    @(posedge CLK); #1;
    e.row = 0; e.col = 0; e.we = 1; e.u = 0; e.l = 0; e.known = 0;
    e.row_e = 0; e.strobe_s = 0; e.ack = 1;
    q.push_back(e);
    bus.ADDR = 21'h0; bus.RW = 1'b1; bus.DRAM = 1'b0; bus.AS = 1'b0;
    bus.UDS = 1'b0; bus.LDS = 1'b0;
    wait_dtack();
    @(negedge CLK); #2 RST = 1'b0;
    #1;
    chk("ack_rst_ras", bus.RAS, 1);
    chk("ack_rst_casu", bus.CASU, 1);
    chk("ack_rst_casl", bus.CASL, 1);
    chk("ack_rst_we", bus.WE, 1);
    chk("ack_rst_dtack", bus.DTACK_DRAM, 1);
    chk("ack_rst_maddr", int'(bus.MADDR), 0);
    q.delete();
    release_bus();
    @(negedge CLK); #2 RST = 1'b1;
    idle_only = 1;
    while (cyc < 605) begin @(posedge CLK); #1; end
    chk("post_rst_ref_count", ref_cnt, 2);
    idle_only = 0;

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
